// File: rtl/ids_rr_arbiter.sv
// ids_rr_arbiter
//   Packet-granular round-robin arbiter in front of the IDS inspection
//   datapath. Each upstream source writes into a small fall-through queue;
//   one queue at a time is granted and whole packets are forwarded on the
//   data/ctrl/wr/rdy bus without interleaving words of different packets.
//
// Ports
//   clk          system clock
//   reset        asynchronous active-low reset
//   in_data      per-port data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ctrl      per-port ctrl, port i at [i*CTRL_WIDTH +: CTRL_WIDTH]
//   in_wr        per-port write strobe
//   in_rdy       per-port ready (queue has more than one free entry)
//   out_data     head word of the granted queue
//   out_ctrl     head ctrl of the granted queue
//   out_wr       word valid toward IDS (queue popped in the same cycle)
//   out_rdy      IDS can accept a word
//   enable       permits new grants
//   grant_valid  a packet is currently granted
//   grant_port   index of the granted port
//   pkt_done     pulse coincident with the last word of a forwarded packet
//   frame_err    pulse coincident with the discard of a misframed head word
//   overflow     sticky per-port flag, write seen while that queue was full
module ids_rr_arbiter #(
  parameter int DATA_WIDTH       = 64,
  parameter int CTRL_WIDTH       = DATA_WIDTH/8,
  parameter int NUM_PORTS        = 2,
  parameter int QUEUE_DEPTH_BITS = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  in_data,
  input  logic [NUM_PORTS*CTRL_WIDTH-1:0]  in_ctrl,
  input  logic [NUM_PORTS-1:0]             in_wr,
  output logic [NUM_PORTS-1:0]             in_rdy,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  input  logic                             out_rdy,
  input  logic                             enable,
  output logic                             grant_valid,
  output logic [1:0]                       grant_port,
  output logic                             pkt_done,
  output logic                             frame_err,
  output logic [NUM_PORTS-1:0]             overflow
);

  localparam int DEPTH = 1 << QUEUE_DEPTH_BITS;
  localparam int CNT_W = QUEUE_DEPTH_BITS + 1;
  localparam int WORD_W = DATA_WIDTH + CTRL_WIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_HEAD, ST_BODY} state_t;

  state_t      state_reg;
  logic        grant_valid_reg;
  logic [1:0]  grant_port_reg;
  logic [1:0]  rr_ptr_reg;
  logic [1:0]  rst_sync_reg;
  logic        run_ok;

  logic [NUM_PORTS-1:0]                 empty;
  logic [NUM_PORTS-1:0]                 full;
  logic [NUM_PORTS-1:0]                 pop;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] head_data;
  logic [NUM_PORTS-1:0][CTRL_WIDTH-1:0] head_ctrl;

  // Reset release is brought onto clk through two flops; arbitration stays
  // off until the released level has propagated.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_reg <= 2'b00;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
  end
  assign run_ok = rst_sync_reg[1];

  // ---------------------------------------------------------------------
  // Per-port fall-through queues: head word is read combinationally from
  // the storage array so a word written at cycle N is at the head at N+1.
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_queue
      logic [WORD_W-1:0]           mem_reg [DEPTH];
      logic [QUEUE_DEPTH_BITS-1:0] wr_ptr_reg;
      logic [QUEUE_DEPTH_BITS-1:0] rd_ptr_reg;
      logic [CNT_W-1:0]            count_reg;
      logic                        overflow_reg;
      logic                        push;

      assign full[gi]   = (count_reg == CNT_W'(DEPTH));
      assign empty[gi]  = (count_reg == '0);
      assign in_rdy[gi] = (count_reg < CNT_W'(DEPTH - 1));
      // A simultaneous pop frees the slot, so a write to a full queue is
      // still taken in that cycle.
      assign push = in_wr[gi] && (!full[gi] || pop[gi]);

      assign head_data[gi] = mem_reg[rd_ptr_reg][DATA_WIDTH-1:0];
      assign head_ctrl[gi] = mem_reg[rd_ptr_reg][WORD_W-1:DATA_WIDTH];
      assign overflow[gi]  = overflow_reg;

      // Storage needs no reset: pointers and count define what is valid.
      always_ff @(posedge clk) begin
        if (push) begin
          mem_reg[wr_ptr_reg] <= {in_ctrl[gi*CTRL_WIDTH +: CTRL_WIDTH],
                                  in_data[gi*DATA_WIDTH +: DATA_WIDTH]};
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          wr_ptr_reg   <= '0;
          rd_ptr_reg   <= '0;
          count_reg    <= '0;
          overflow_reg <= 1'b0;
        end else begin
          if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
          end
          if (pop[gi]) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
          end
          case ({push, pop[gi]})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
          endcase
          if (in_wr[gi] && full[gi] && !pop[gi]) begin
            overflow_reg <= 1'b1;
          end
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Round-robin scan from rr_ptr. The first non-empty queue with a
  // misframed head (ctrl==0) is a discard candidate; the first non-empty
  // queue with a proper header is the grant candidate.
  // ---------------------------------------------------------------------
  logic       disc_found;
  logic [1:0] disc_port;
  logic       req_found;
  logic [1:0] req_port;

  always_comb begin
    disc_found = 1'b0;
    disc_port  = 2'd0;
    req_found  = 1'b0;
    req_port   = 2'd0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if ((((int'(rr_ptr_reg) + k) % NUM_PORTS) == p) && !empty[p]) begin
          if (head_ctrl[p] == '0) begin
            if (!disc_found) begin
              disc_found = 1'b1;
              disc_port  = 2'(p);
            end
          end else if (!req_found) begin
            req_found = 1'b1;
            req_port  = 2'(p);
          end
        end
      end
    end
  end

  // Head of the granted queue.
  logic                  sel_empty;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [CTRL_WIDTH-1:0] sel_ctrl;

  always_comb begin
    sel_empty = 1'b1;
    sel_data  = '0;
    sel_ctrl  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_port_reg == 2'(p)) begin
        sel_empty = empty[p];
        sel_data  = head_data[p];
        sel_ctrl  = head_ctrl[p];
      end
    end
  end

  logic in_idle;
  logic discard;
  logic grant;
  logic last_word;
  logic [1:0] rr_next;

  assign in_idle   = (state_reg == ST_IDLE);
  // Discarding a misframed head takes priority over granting that cycle.
  assign discard   = in_idle && run_ok && disc_found;
  assign grant     = in_idle && run_ok && enable && !disc_found && req_found;
  assign out_wr    = grant_valid_reg && !sel_empty && out_rdy && !in_idle;
  assign last_word = out_wr && (state_reg == ST_BODY) && (sel_ctrl != '0);
  assign rr_next   = (grant_port_reg == 2'(NUM_PORTS - 1)) ? 2'd0
                                                           : grant_port_reg + 2'd1;

  always_comb begin
    pop = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if ((out_wr && grant_port_reg == 2'(p)) ||
          (discard && disc_port == 2'(p))) begin
        pop[p] = 1'b1;
      end
    end
  end

  assign out_data    = sel_data;
  assign out_ctrl    = sel_ctrl;
  assign grant_valid = grant_valid_reg;
  assign grant_port  = grant_port_reg;
  assign pkt_done    = last_word;
  assign frame_err   = discard;

  // ---------------------------------------------------------------------
  // Packet FSM: IDLE arbitrates, HEAD passes header words, BODY passes
  // body words until the closing ctrl!=0 word.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= ST_IDLE;
      grant_valid_reg <= 1'b0;
      grant_port_reg  <= 2'd0;
      rr_ptr_reg      <= 2'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (grant) begin
            grant_port_reg  <= req_port;
            grant_valid_reg <= 1'b1;
            state_reg       <= ST_HEAD;
          end
        end
        ST_HEAD: begin
          if (out_wr && sel_ctrl == '0) begin
            state_reg <= ST_BODY;
          end
        end
        ST_BODY: begin
          if (last_word) begin
            rr_ptr_reg      <= rr_next;
            grant_valid_reg <= 1'b0;
            state_reg       <= ST_IDLE;
          end
        end
        default: begin
          state_reg       <= ST_IDLE;
          grant_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ids_rr_arbiter.sv
// Testbench for ids_rr_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based reference model.
module tb_ids_rr_arbiter;

  localparam int DW    = 64;
  localparam int CW    = 8;
  localparam int NP    = 2;
  localparam int DEPTH = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [NP*DW-1:0]    in_data = '0;
  logic [NP*CW-1:0]    in_ctrl = '0;
  logic [NP-1:0]       in_wr = '0;
  logic [NP-1:0]       in_rdy;
  logic [DW-1:0]       out_data;
  logic [CW-1:0]       out_ctrl;
  logic                out_wr;
  logic                out_rdy = 1'b0;
  logic                enable = 1'b0;
  logic                grant_valid;
  logic [1:0]          grant_port;
  logic                pkt_done;
  logic                frame_err;
  logic [NP-1:0]       overflow;

  always #5 clk = ~clk;

  ids_rr_arbiter #(
    .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_PORTS(NP), .QUEUE_DEPTH_BITS(2)
  ) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .enable(enable), .grant_valid(grant_valid), .grant_port(grant_port),
    .pkt_done(pkt_done), .frame_err(frame_err), .overflow(overflow)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: each source queue is a plain SV queue of {ctrl,data};
  // the arbiter is "which port owns the output, has its body started, and
  // who is next in the rotation".
  logic [CW+DW-1:0] mq [NP][$];
  bit               m_busy;
  bit               m_body;
  int               m_port;
  int               m_rr;
  int               m_sync;
  bit [NP-1:0]      m_ovf;

  // Random packet generator state per port.
  int gen_hdr  [NP];
  int gen_body [NP];
  bit gen_last [NP];

  task automatic clear_inputs();
    in_wr   = '0;
    in_data = '0;
    in_ctrl = '0;
  endtask

  task automatic set_port(input int p, input logic [CW+DW-1:0] w);
    in_wr[p] = 1'b1;
    in_ctrl[p*CW +: CW] = w[CW+DW-1:DW];
    in_data[p*DW +: DW] = w[DW-1:0];
  endtask

  function automatic logic [CW+DW-1:0] pkt_word(input int i, input int tag);
    logic [CW-1:0] c;
    c = (i == 0) ? 8'hFF : ((i == 4) ? 8'h80 : 8'h00);
    return {c, 32'(tag), 32'(i)};
  endfunction

  task automatic gen_word(input int p, output logic [CW+DW-1:0] w);
    logic [DW-1:0] d;
    d = {$urandom(), $urandom()};
    if (gen_hdr[p] == 0 && gen_body[p] == 0 && !gen_last[p] && $urandom_range(0, 19) == 0) begin
      w = {8'h00, d};                       // stray word outside any packet
    end else begin
      if (gen_hdr[p] == 0 && gen_body[p] == 0 && !gen_last[p]) begin
        gen_hdr[p]  = int'($urandom_range(1, 2));
        gen_body[p] = int'($urandom_range(1, 3));
        gen_last[p] = 1'b1;
      end
      if (gen_hdr[p] > 0) begin
        w = {8'($urandom_range(1, 255)), d};
        gen_hdr[p]--;
      end else if (gen_body[p] > 0) begin
        w = {8'h00, d};
        gen_body[p]--;
      end else begin
        w = {8'($urandom_range(1, 255)), d};
        gen_last[p] = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) mq[p].delete();
    m_busy = 0; m_body = 0; m_port = 0; m_rr = 0; m_sync = 0; m_ovf = '0;
  endtask

  // One clock cycle: inputs are already driven (we sit just after a negedge).
  // Check every output against the model, advance the model, then wait for
  // the next negedge.
  task automatic cycle();
    bit ok, exp_wr, exp_done;
    int disc, gnt, p;
    logic [CW+DW-1:0] word;
    bit [NP-1:0] mpop;
    #1;
    ok = (m_sync >= 2);
    exp_wr = m_busy && (mq[m_port].size() > 0) && out_rdy;
    word = exp_wr ? mq[m_port][0] : '0;
    exp_done = exp_wr && m_body && (word[CW+DW-1:DW] != 0);
    disc = -1;
    gnt  = -1;
    if (!m_busy && ok) begin
      for (int k = 0; k < NP; k++) begin
        p = (m_rr + k) % NP;
        if (mq[p].size() > 0) begin
          if (mq[p][0][CW+DW-1:DW] == 0) begin
            if (disc < 0) disc = p;
          end else if (gnt < 0) begin
            gnt = p;
          end
        end
      end
      if (disc >= 0 || !enable) gnt = -1;
    end

    check_eq("out_wr", 72'(out_wr), 72'(exp_wr));
    if (exp_wr) begin
      check_eq("out_data", 72'(out_data), 72'(word[DW-1:0]));
      check_eq("out_ctrl", 72'(out_ctrl), 72'(word[CW+DW-1:DW]));
    end
    check_eq("pkt_done", 72'(pkt_done), 72'(exp_done));
    check_eq("frame_err", 72'(frame_err), 72'(disc >= 0));
    check_eq("grant_valid", 72'(grant_valid), 72'(m_busy));
    check_eq("grant_port", 72'(grant_port), 72'(m_port));
    for (int q = 0; q < NP; q++) begin
      check_eq("in_rdy", 72'(in_rdy[q]), 72'(mq[q].size() < DEPTH - 1));
    end
    check_eq("overflow", 72'(overflow), 72'(m_ovf));

    if (exp_done) $display("pkt_done port %0d last ctrl %0h", m_port, word[CW+DW-1:DW]);
    if (disc >= 0) $display("frame_err discard port %0d", disc);

    // Model update.
    mpop = '0;
    if (exp_wr) mpop[m_port] = 1'b1;
    if (disc >= 0) mpop[disc] = 1'b1;
    for (int q = 0; q < NP; q++) begin
      if (mpop[q]) void'(mq[q].pop_front());
    end
    for (int q = 0; q < NP; q++) begin
      if (in_wr[q]) begin
        if (mq[q].size() < DEPTH) mq[q].push_back({in_ctrl[q*CW +: CW], in_data[q*DW +: DW]});
        else m_ovf[q] = 1'b1;
      end
    end
    if (exp_wr) begin
      if (word[CW+DW-1:DW] == 0) begin
        m_body = 1'b1;
      end else if (m_body) begin
        m_busy = 0;
        m_body = 0;
        m_rr = (m_port + 1) % NP;
      end
    end
    if (gnt >= 0) begin
      m_busy = 1;
      m_body = 0;
      m_port = gnt;
    end
    m_sync++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      clear_inputs();
      cycle();
    end
  endtask

  logic [CW+DW-1:0] w;

  initial begin
    for (int p = 0; p < NP; p++) begin
      gen_hdr[p] = 0; gen_body[p] = 0; gen_last[p] = 0;
    end
    @(negedge clk);
    do_reset();
    out_rdy = 1'b1;
    enable  = 1'b1;

    // Reset state seen at the first cycle after release.
    check_eq("rst_grant_valid", 72'(grant_valid), 72'(0));
    check_eq("rst_overflow", 72'(overflow), 72'(0));

    // Single packet on port 0.
    for (int i = 0; i < 5; i++) begin
      clear_inputs(); set_port(0, pkt_word(i, 1)); cycle();
    end
    idle_cycles(6);

    // Ports 0 and 1 each hold a packet at reset release; port 0 gets a
    // second packet while port 1 is being served.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      clear_inputs(); set_port(0, pkt_word(i, 2)); set_port(1, pkt_word(i, 3)); cycle();
    end
    idle_cycles(4);
    for (int i = 0; i < 5; i++) begin
      clear_inputs(); set_port(0, pkt_word(i, 4)); cycle();
    end
    idle_cycles(10);

    // Port 1 packet with out_rdy toggling.
    for (int i = 0; i < 5; i++) begin
      clear_inputs(); out_rdy = i[0]; set_port(1, pkt_word(i, 5)); cycle();
    end
    for (int i = 0; i < 12; i++) begin
      clear_inputs(); out_rdy = i[0]; cycle();
    end
    out_rdy = 1'b1;
    idle_cycles(3);

    // Misframed head on port 0, then a valid packet.
    clear_inputs(); set_port(0, {8'h00, 64'hDEAD}); cycle();
    for (int i = 0; i < 5; i++) begin
      clear_inputs(); set_port(0, pkt_word(i, 6)); cycle();
    end
    idle_cycles(8);

    // Overflow: six writes while out_rdy=0.
    do_reset();
    out_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      clear_inputs(); set_port(0, pkt_word((i > 4) ? 4 : i, 7)); cycle();
    end
    idle_cycles(3);
    out_rdy = 1'b1;
    idle_cycles(6);
    clear_inputs(); set_port(0, pkt_word(4, 8)); cycle();
    idle_cycles(4);

    // Reset asserted while port 1 is in its body.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      clear_inputs(); set_port(1, pkt_word(i, 9)); cycle();
    end
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      clear_inputs(); if (i < 2) set_port(1, pkt_word(1, 9)); cycle();
    end
    clear_inputs();
    out_rdy = 1'b1;
    #1;
    check_eq("pre_rst_wr", 72'(out_wr), 72'(1));
    #1;
    reset = 1'b0;
    #1;
    check_eq("rst_async_wr", 72'(out_wr), 72'(0));
    check_eq("rst_async_gv", 72'(grant_valid), 72'(0));
    check_eq("rst_async_gp", 72'(grant_port), 72'(0));
    check_eq("rst_async_rdy", 72'(in_rdy), 72'({NP{1'b1}}));
    @(negedge clk);
    do_reset();
    idle_cycles(4);
    for (int i = 0; i < 5; i++) begin
      clear_inputs(); set_port(1, pkt_word(i, 10)); set_port(0, pkt_word(i, 11)); cycle();
    end
    idle_cycles(14);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      clear_inputs();
      out_rdy = ($urandom_range(0, 3) != 0);
      enable  = ($urandom_range(0, 9) != 0);
      for (int p = 0; p < NP; p++) begin
        if ((mq[p].size() < DEPTH - 1 && $urandom_range(0, 9) < 6) ||
            $urandom_range(0, 99) < 3) begin
          gen_word(p, w);
          set_port(p, w);
        end
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ids_rr_arbiter.md
Name: ids_rr_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single IDS inspection datapath among NUM_PORTS upstream packet sources.
- Each source feeds a small fall-through input queue. The arbiter grants one queue at a time and forwards whole packets, never interleaving words of different packets.
- It sits directly upstream of the IDS module in the user data path. Its output uses the standard data/ctrl/wr/rdy bus.

Parameters:
DATA_WIDTH, 64, data bus width per word
CTRL_WIDTH, DATA_WIDTH/8, ctrl bus width per word
NUM_PORTS, 2, number of requesting sources (legal range 2..4)
QUEUE_DEPTH_BITS, 2, log2 of per-port queue depth (4 words)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
in_data  in  NUM_PORTS*DATA_WIDTH  per-port data; port i occupies slice [i*DATA_WIDTH +: DATA_WIDTH]
in_ctrl  in  NUM_PORTS*CTRL_WIDTH  per-port ctrl, same slicing
in_wr  in  NUM_PORTS  per-port write strobe
in_rdy  out  NUM_PORTS  per-port ready (queue not nearly full)
out_data  out  DATA_WIDTH  word to IDS
out_ctrl  out  CTRL_WIDTH  ctrl to IDS
out_wr  out  1  word valid toward IDS
out_rdy  in  1  IDS can accept a word
enable  in  1  permits new grants
grant_valid  out  1  a packet is currently granted
grant_port  out  2  index of granted port
pkt_done  out  1  one-cycle pulse on the last word of a forwarded packet
frame_err  out  1  one-cycle pulse when a misframed word is discarded
overflow  out  NUM_PORTS  sticky; set when in_wr is seen while that queue is full

Behaviour:
- Packet framing:
  - One or more leading words with ctrl!=0 (header).
  - Then words with ctrl==0 (body).
  - Then the first subsequent word with ctrl!=0 is the last word.
- Queues:
  - Per port, fall-through, depth 2^QUEUE_DEPTH_BITS.
  - in_rdy[i] = !nearly_full[i], where nearly full means one free entry.
  - A word written at cycle N is visible at the queue head at cycle N+1.
  - A write to a full queue is dropped and sets overflow[i]. overflow clears only on reset.
- FSM states: IDLE, HEAD, BODY.
  - IDLE: when enable=1, scan non-empty queues starting at rr_ptr, wrapping mod NUM_PORTS. Pick the first queue whose head word has ctrl!=0. Register grant_port, set grant_valid=1, go to HEAD. Arbitration costs exactly one cycle; no word is forwarded in the arbitration cycle.
  - IDLE, misframed head: a non-empty queue whose head has ctrl==0 is popped without output and frame_err pulses. This takes one discard per cycle, lowest index from rr_ptr first, and takes precedence over granting in that cycle.
  - HEAD: forward one word per cycle when the granted queue is non-empty and out_rdy=1. A forwarded word with ctrl==0 moves the FSM to BODY.
  - BODY: forward under the same rule. A forwarded word with ctrl!=0 is the last word: pulse pkt_done, set rr_ptr = (grant_port+1) mod NUM_PORTS, clear grant_valid, go to IDLE.
- Forwarding is combinational, fall-through style:
  - out_wr = grant_valid & !empty[grant_port] & out_rdy & (state!=IDLE).
  - out_data and out_ctrl are the head of the granted queue.
  - The granted queue is popped in the same cycle as out_wr.
- Back-to-back packets: minimum one idle output cycle between packets, for the arbitration cycle.
- enable:
  - Deasserting enable mid-packet does not truncate the packet; it completes.
  - No new grant occurs while enable=0. Misframed-word discards still occur in IDLE while enable=0.
- Simultaneous events:
  - A write and a pop on the same queue in one cycle are both honoured.
  - A write arriving at a full queue in the same cycle as a pop is accepted.
- Reset (reset=0, asynchronous):
  - All queues are flushed. state=IDLE, rr_ptr=0.
  - Outputs: grant_valid=0, grant_port=0, pkt_done=0, frame_err=0, overflow=0, out_wr=0.
  - A packet in flight is abandoned; no partial-packet recovery is performed.
- Release of reset is synchronised internally before the first grant.

Test Plan:
- Single packet on port 0 (header ctrl=0xFF, 3 body words ctrl=0, last ctrl=0x80), out_rdy=1 -> 5 words out in order; out_wr is contiguous after a 1-cycle arbitration; pkt_done on word 5; grant_port=0.
- Ports 0 and 1 each hold one packet at reset release -> port 0 is forwarded first, then port 1 after one idle cycle. Adding a new port-0 packet during port 1's packet is served after it (rr_ptr rotation).
- Port 1 is mid-packet and out_rdy toggles 1,0,1,0 -> out_wr is asserted only when out_rdy=1; no word lost or duplicated; port 0 is never interleaved.
- Port 0 head word has ctrl=0 in IDLE -> popped, frame_err pulses once, out_wr=0, and the following valid packet is granted normally.
- 6 back-to-back in_wr on port 0 while out_rdy=0 -> in_rdy[0] drops after 3 words; the 5th and later writes set overflow[0]=1; the queue holds exactly 4 words.
- reset asserted in BODY while port 1 is granted -> out_wr and grant_valid go to 0 immediately without a clock; after release the queues are empty and rr_ptr=0.
